// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, followed by one sign-fix cycle that commits HI/LO.
module mul_div_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic                is_div_q, is_div_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;

    // Operand preparation for a new command
    logic            is_signed;
    logic            rs_neg, rt_neg;
    logic [XLEN-1:0] rs_mag, rt_mag;

    always_comb begin
        is_signed = ~op[0];
        rs_neg    = is_signed & rs_val[XLEN-1];
        rt_neg    = is_signed & rt_val[XLEN-1];
        rs_mag    = rs_neg ? (~rs_val + 1'b1) : rs_val;
        rt_mag    = rt_neg ? (~rt_val + 1'b1) : rt_val;
    end

    // One iteration of each algorithm; acc holds {upper, lower} halves
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_top;
    logic            div_ge;
    logic [XLEN-1:0] div_rem;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_top = acc_q[2*XLEN-1:XLEN-1];
        div_ge  = div_top >= {1'b0, opb_q};
        // The true difference always fits XLEN bits when div_ge holds
        div_rem = div_ge ? (div_top[XLEN-1:0] - opb_q) : div_top[XLEN-1:0];
    end

    // Sign correction of the finished magnitudes
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quot_fix = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !op[2]) begin
                    acc_d     = {{XLEN{1'b0}}, rs_mag};
                    opb_d     = rt_mag;
                    is_div_d  = op[1];
                    neg_res_d = rs_neg ^ rt_neg;
                    neg_rem_d = rs_neg;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_CALC;
                end else if (start && op == 3'b100) begin
                    hi_d = rs_val;
                end else if (start && op == 3'b101) begin
                    lo_d = rs_val;
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    acc_d = {div_rem, acc_q[XLEN-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (opb_q == '0) begin
                    dbz_d = 1'b1;
                end else begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed and random commands compared
// against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] mh, ml;

    mul_div_unit #(.XLEN(32), .ITER(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: 64-bit arithmetic straight from the instruction definitions
    function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] h, inout logic [31:0] l, output logic dz);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0] ua, ub, up;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        ua = {32'h0, a};
        ub = {32'h0, b};
        dz = 1'b0;
        case (o)
            3'd0: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
            3'd1: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
            3'd2: if (b == 0) dz = 1'b1;
                  else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
            3'd3: if (b == 0) dz = 1'b1;
                  else begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endfunction

    // Issue one multiply/divide and wait (bounded) for done
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy_ok, output logic busy_at_done,
                         output logic [31:0] h, output logic [31:0] l, output logic dz);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        busy_at_done = busy;
        h = hi; l = lo; dz = div_by_zero;
    endtask

    task automatic check_result(input string name, input logic [2:0] o,
                                input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic bok, bad, dz, edz;
        logic [31:0] h, l;
        ref_op(o, a, b, mh, ml, edz);
        do_op(o, a, b, lat, bok, bad, h, l, dz);
        checks++;
        if (lat != 33 || bok !== 1'b1 || bad !== 1'b0) begin
            errors++;
            $display("FAIL %s timing: latency=%0d busy_ok=%b busy_at_done=%b required latency=33 busy_ok=1 busy_at_done=0",
                     name, lat, bok, bad);
        end
        checks++;
        if (h !== mh || l !== ml || dz !== edz) begin
            errors++;
            $display("FAIL %s result: op=%0d a=%h b=%h hi=%h lo=%h dbz=%b required hi=%h lo=%h dbz=%b",
                     name, o, a, b, h, l, dz, mh, ml, edz);
        end
        $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b lat=%0d", name, o, a, b, h, l, dz, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dbz=%b required all zero",
                     hi, lo, busy, done, div_by_zero);
        end
        $display("txn reset hi=%h lo=%h busy=%b", hi, lo, busy);
        @(negedge clk);
        reset = 1'b0;
        mh = '0; ml = '0;
    endtask

    task automatic test_mthi_mtlo();
        logic dz;
        logic [31:0] r;
        for (int i = 0; i < 3; i++) begin
            logic [2:0] o;
            o = (i == 0) ? 3'd4 : (i == 1) ? 3'd5 : 3'd6;
            r = (i == 0) ? 32'h12345678 : $urandom;
            ref_op(o, r, 32'h0, mh, ml, dz);
            @(negedge clk);
            start = 1'b1; op = o; rs_val = r;
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (hi !== mh || lo !== ml || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL move_op%0d: hi=%h lo=%h busy=%b done=%b required hi=%h lo=%h busy=0 done=0",
                         o, hi, lo, busy, done, mh, ml);
            end
            $display("txn move op=%0d rs=%h -> hi=%h lo=%h", o, r, hi, lo);
        end
    endtask

    task automatic test_mult();
        check_result("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5);
        checks++;
        if (mh !== 32'hFFFFFFFF || ml !== 32'hFFFFFFF1) begin
            errors++;
            $display("FAIL mult_model: hi=%h lo=%h required FFFFFFFF FFFFFFF1", mh, ml);
        end
        check_result("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
        end
        check_result("mult_minmin", 3'd0, 32'h80000000, 32'h80000000);
    endtask

    task automatic test_div();
        check_result("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2);
        check_result("divu_100_7", 3'd3, 32'd100, 32'd7);
        check_result("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        check_result("div_neg_neg", 3'd2, 32'hFFFFFF9C, 32'hFFFFFFF9);
        check_result("divu_big", 3'd3, 32'hFFFFFFFF, 32'h00000001);
    endtask

    task automatic test_div_by_zero();
        logic dz;
        ref_op(3'd4, 32'hAAAA0000, 32'h0, mh, ml, dz);
        ref_op(3'd5, 32'h0000BBBB, 32'h0, mh, ml, dz);
        @(negedge clk); start = 1'b1; op = 3'd4; rs_val = 32'hAAAA0000;
        @(negedge clk); op = 3'd5; rs_val = 32'h0000BBBB;
        @(negedge clk); start = 1'b0;
        check_result("divu_zero", 3'd3, 32'h12345678, 32'h0);
        @(posedge clk); #1;
        checks++;
        if (div_by_zero !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL dbz_pulse: dbz=%b done=%b one cycle later, required 0 0", div_by_zero, done);
        end
        check_result("div_zero", 3'd2, 32'h80000000, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [2:0] o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 3));
                1: b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            check_result("random", o, a, b);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        logic dz;
        ref_op(3'd0, 32'h00012345, 32'hFFFF0007, mh, ml, dz);
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs_val = 32'h00012345; rt_val = 32'hFFFF0007;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = 3'd3; rs_val = 32'd1000; rt_val = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 5;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != 33 || hi !== mh || lo !== ml) begin
            errors++;
            $display("FAIL busy_ignore: latency=%0d hi=%h lo=%h required latency=33 hi=%h lo=%h",
                     lat, hi, lo, mh, ml);
        end
        $display("txn busy_ignore -> hi=%h lo=%h lat=%0d", hi, lo, lat);
        // Stay idle long enough to prove the ignored DIVU never runs
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (hi !== mh || lo !== ml) begin
            errors++;
            $display("FAIL busy_ignore_late: hi=%h lo=%h required hi=%h lo=%h", hi, lo, mh, ml);
        end
    endtask

    // do_op returns in the done cycle, so the next call issues start there
    task automatic test_back_to_back();
        check_result("b2b_first", 3'd1, 32'h0000FFFF, 32'h00010001);
        check_result("b2b_second", 3'd2, 32'h7FFFFFFF, 32'hFFFFFFFE);
        check_result("b2b_third", 3'd0, 32'hDEADBEEF, 32'h00000003);
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs_val = 32'd12345; rt_val = 32'd17;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        mh = '0; ml = '0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b hi=%h lo=%h done=%b required 0 0 0 0", busy, hi, lo, done);
        end
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_done: aborted op produced done/busy activity=%b required 0", saw_done);
        end
        $display("txn reset_abort -> hi=%h lo=%h busy=%b", hi, lo, busy);
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_div();
        test_div_by_zero();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the EX stage of the MIPS core.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds the architectural HI and LO registers.
- HI and LO feed the 32-bit writeback/result selector for MFHI/MFLO, one input each. The selector is downstream of this block.
- Exposes busy so the hazard unit can stall the pipeline.

Parameters:
- XLEN, 32, operand and HI/LO width.
- ITER, 32, iteration count for multiply and divide (must equal XLEN).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  command valid; sampled only when busy=0.
- op  input  3  command: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- rs_val  input  XLEN  multiplicand / dividend / MTHI-MTLO source.
- rt_val  input  XLEN  multiplier / divisor.
- busy  output  1  high while a multiply/divide is in flight.
- done  output  1  one-cycle pulse; HI/LO hold the new result in that cycle.
- div_by_zero  output  1  one-cycle pulse coincident with done for a DIV/DIVU with rt_val=0.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0. State=IDLE, iteration counter=0. Reset has priority over everything, including mid-operation: the in-flight result is discarded and no done is produced.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 with op MTHI/MTLO: hi (or lo) <= rs_val at that edge. No busy, no done. Stay in IDLE.
  - start=1 with MULT/MULTU/DIV/DIVU at edge E:
    - latch operand magnitudes (absolute values for the signed ops) and the result signs;
    - clear the accumulator, counter <= 0, busy <= 1;
    - go to CALC.
  - start=1 with op 110/111: ignored.
- CALC: one iteration per edge, counter increments.
  - Multiply: shift-add over a 64-bit product, unsigned on magnitudes.
  - Divide: restoring shift-subtract giving a 32-bit quotient and remainder on magnitudes.
  - After the ITER-th iteration (edge E+32): go to FIX.
- FIX (edge E+33): apply sign correction, write hi/lo, pulse done, busy <= 0, go to IDLE. Results:
  - MULT/MULTU: {hi,lo} = 64-bit product. For MULT the product is negated if the operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder.
    - Signed quotient truncates toward zero.
    - Remainder takes the dividend's sign.
    - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
  - Divide by zero: the full latency still elapses; hi/lo are unchanged; div_by_zero=1 alongside done.
- Latency: start sampled at edge E; busy high from after E through the cycle before done; done, div_by_zero and new hi/lo visible after edge E+33.
- start while busy=1 is ignored; operands are not re-latched. The stall contract is the hazard unit's job.
- In the done cycle busy=0, so a new start is accepted at that same next edge (back-to-back operations).
- hi/lo are stable at all times except for single-edge updates at FIX or on MTHI/MTLO.
- No partial results are ever exposed.
- done and div_by_zero deassert after one cycle.

Test Plan:
- Reset then idle: hi=0, lo=0, busy=0, done=0. MTHI rs_val=0x12345678 → hi=0x12345678 after one edge, busy stays 0.
- MULT rs_val=0xFFFFFFFD (-3), rt_val=5 → busy high 33 cycles; done after E+33 with hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs_val=0xFFFFFFF9 (-7), rt_val=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU rt_val=0 with prior hi=0xAAAA0000, lo=0x0000BBBB → done and div_by_zero both pulse at E+33; hi/lo unchanged.
- MULT started, second start (DIVU) asserted at E+5 → ignored; result equals the MULT only. A new start in the done cycle begins immediately, and its done arrives 33 edges later.
- reset asserted at E+10 of a DIV → next cycle: busy=0, hi=lo=0, no done pulse ever appears for the aborted op.
